// File: rtl/spi_slave_regif.sv
// SPI mode-0 target: oversamples SCLK/CS/MOSI in the 25 MHz domain and turns 24-bit frames
// {rw, 7'b0, addr, data} into single-cycle register read/write strobes, returning read data on MISO.
module spi_slave_regif #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  sys_clk_25m,
  input  logic                  sys_rst,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  frame_err
);

  localparam int FRAME_BITS = 16 + DATA_WIDTH;
  localparam int CW         = $clog2(FRAME_BITS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [1:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [14:0]           hdr_shift;
  logic [15:0]           hdr_next;
  logic [DATA_WIDTH-1:0] rx_shift, rx_next;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  rw, rd_cap, tx_vld;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_comb begin
    hdr_next = {hdr_shift, mosi_s};
    rx_next  = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  end

  // CS chain resets to the deasserted level so leaving reset never looks like a CS edge.
  always_ff @(posedge sys_clk_25m) begin
    if (sys_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge sys_clk_25m) begin
    if (sys_rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      hdr_shift   <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rw          <= 1'b0;
      rd_cap      <= 1'b0;
      tx_vld      <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      frame_err   <= 1'b0;
      spi_miso_oe <= ~cs_s;
      rd_cap      <= reg_rd_en;
      // Read data is valid one cycle after the strobe; capture it then.
      if (rd_cap) begin
        tx_shift <= reg_rd_data;
        tx_vld   <= 1'b1;
      end
      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          tx_vld   <= 1'b0;
          if (cs_fall) begin
            state   <= HDR;
            bit_cnt <= '0;
          end
        end
        HDR: begin
          if (cs_rise) begin
            frame_err <= (bit_cnt != '0);
            state     <= IDLE;
          end else if (sclk_rise) begin
            hdr_shift <= hdr_next[14:0];
            bit_cnt   <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(15)) begin
              reg_addr  <= hdr_next[ADDR_WIDTH-1:0];
              rw        <= hdr_next[15];
              reg_rd_en <= hdr_next[15];
              state     <= DATA;
            end
          end
        end
        DATA: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
            state     <= IDLE;
          end else begin
            if (sclk_fall && rw && tx_vld) begin
              spi_miso <= tx_shift[DATA_WIDTH-1];
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(FRAME_BITS - 1)) begin
                if (!rw) begin
                  reg_wr_en   <= 1'b1;
                  reg_wr_data <= rx_next;
                end
                state <= HOLD;
              end
            end
          end
        end
        default: begin
          spi_miso <= 1'b0;
          if (cs_rise) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: drives SPI frames and compares strobes, addresses, write data and
// MISO read-back against a register-bank model built from the frame format.
module tb_spi_slave_regif;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic       reg_wr_en, reg_rd_en, frame_err;

  logic [7:0] bank [256];
  logic [7:0] model_mem [256];

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] last_wr_addr, last_wr_data, last_rd_addr;

  always #20 clk = ~clk;

  spi_slave_regif #(.SYNC_STAGES(2), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .sys_clk_25m(clk), .sys_rst(sys_rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .frame_err(frame_err)
  );

  assign reg_rd_data = bank[reg_addr];

  // Register bank side: observe strobes away from the clock edge.
  always @(negedge clk) begin
    if (!sys_rst) begin
      if (reg_wr_en) begin
        wr_cnt++;
        bank[reg_addr] = reg_wr_data;
        last_wr_addr = reg_addr;
        last_wr_data = reg_wr_data;
      end
      if (reg_rd_en) begin
        rd_cnt++;
        last_rd_addr = reg_addr;
      end
      if (frame_err) err_cnt++;
      if (reg_wr_en && reg_rd_en) both_cnt++;
    end
  end

  // so[23-i] holds MISO as seen just before rise i (the initiator's sample point).
  task automatic run_frame(input logic [23:0] f, input int nbits, input int half,
                           input int gap, input bit end_cs, output logic [23:0] so);
    so = '0;
    spi_cs_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 24) ? f[23-i] : 1'($urandom);
      repeat (half) @(negedge clk);
      if (i < 24) so[23-i] = spi_miso;
      spi_clk = 1'b1;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
    end
    if (end_cs) begin
      repeat (half) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (gap) @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    checks += 7;
    if (spi_miso !== 1'b0)    begin failures++; $display("FAIL rst_miso: got %b want 0", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rst_oe: got %b want 0", spi_miso_oe); end
    if (reg_addr !== 8'h00)   begin failures++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
    if (reg_wr_en !== 1'b0)   begin failures++; $display("FAIL rst_wr_en: got %b want 0", reg_wr_en); end
    if (reg_wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr_data: got %h want 00", reg_wr_data); end
    if (reg_rd_en !== 1'b0)   begin failures++; $display("FAIL rst_rd_en: got %b want 0", reg_rd_en); end
    if (frame_err !== 1'b0)   begin failures++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    sys_rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic test_write();
    int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    logic [23:0] so;
    run_frame(24'h0012A5, 24, 8, 8, 1'b1, so);
    model_mem[8'h12] = 8'hA5;
    checks += 6;
    if (wr_cnt - w0 !== 1)       begin failures++; $display("FAIL wr_count: got %0d want 1", wr_cnt - w0); end
    if (last_wr_addr !== 8'h12)  begin failures++; $display("FAIL wr_addr: got %h want 12", last_wr_addr); end
    if (last_wr_data !== 8'hA5)  begin failures++; $display("FAIL wr_data: got %h want a5", last_wr_data); end
    if (rd_cnt - r0 !== 0)       begin failures++; $display("FAIL wr_no_rd: got %0d want 0", rd_cnt - r0); end
    if (err_cnt - e0 !== 0)      begin failures++; $display("FAIL wr_no_err: got %0d want 0", err_cnt - e0); end
    if (spi_miso_oe !== 1'b0)    begin failures++; $display("FAIL wr_oe_after: got %b want 0", spi_miso_oe); end
  endtask

  task automatic test_read();
    int w0 = wr_cnt, r0 = rd_cnt;
    logic [23:0] so;
    bank[8'h34] = 8'h5C;
    model_mem[8'h34] = 8'h5C;
    run_frame(24'h803400, 24, 8, 0, 1'b0, so);
    checks++;
    if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL rd_oe_active: got %b want 1", spi_miso_oe); end
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    checks += 5;
    if (rd_cnt - r0 !== 1)      begin failures++; $display("FAIL rd_count: got %0d want 1", rd_cnt - r0); end
    if (last_rd_addr !== 8'h34) begin failures++; $display("FAIL rd_addr: got %h want 34", last_rd_addr); end
    if (so[7:0] !== 8'h5C)      begin failures++; $display("FAIL rd_miso: got %h want 5c", so[7:0]); end
    if (wr_cnt - w0 !== 0)      begin failures++; $display("FAIL rd_no_wr: got %0d want 0", wr_cnt - w0); end
    if (spi_miso !== 1'b0)      begin failures++; $display("FAIL rd_miso_idle: got %b want 0", spi_miso); end
  endtask

  task automatic test_abort();
    int w0 = wr_cnt, e0 = err_cnt;
    logic [23:0] so;
    logic [7:0] a, d;
    run_frame(24'h0055AA, 10, 6, 8, 1'b1, so);
    checks += 2;
    if (err_cnt - e0 !== 1) begin failures++; $display("FAIL abort_err: got %0d want 1", err_cnt - e0); end
    if (wr_cnt - w0 !== 0)  begin failures++; $display("FAIL abort_no_wr: got %0d want 0", wr_cnt - w0); end
    a = 8'($urandom); d = 8'($urandom);
    w0 = wr_cnt; e0 = err_cnt;
    run_frame({8'h00, a, d}, 24, 6, 8, 1'b1, so);
    model_mem[a] = d;
    checks += 4;
    if (wr_cnt - w0 !== 1)  begin failures++; $display("FAIL post_abort_wr: got %0d want 1", wr_cnt - w0); end
    if (last_wr_addr !== a) begin failures++; $display("FAIL post_abort_addr: got %h want %h", last_wr_addr, a); end
    if (last_wr_data !== d) begin failures++; $display("FAIL post_abort_data: got %h want %h", last_wr_data, d); end
    if (err_cnt - e0 !== 0) begin failures++; $display("FAIL post_abort_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_long_frame();
    int w0 = wr_cnt, e0 = err_cnt;
    logic [23:0] so;
    run_frame(24'h00073C, 32, 6, 8, 1'b1, so);
    model_mem[8'h07] = 8'h3C;
    checks += 4;
    if (wr_cnt - w0 !== 1)      begin failures++; $display("FAIL long_wr_count: got %0d want 1", wr_cnt - w0); end
    if (last_wr_addr !== 8'h07) begin failures++; $display("FAIL long_addr: got %h want 07", last_wr_addr); end
    if (last_wr_data !== 8'h3C) begin failures++; $display("FAIL long_data: got %h want 3c", last_wr_data); end
    if (err_cnt - e0 !== 0)     begin failures++; $display("FAIL long_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    logic [23:0] so;
    logic [7:0] a, d;
    run_frame(24'h803400, 20, 6, 0, 1'b0, so);
    sys_rst = 1'b1;
    spi_cs_n = 1'b1;
    @(negedge clk);
    checks += 6;
    if (reg_addr !== 8'h00)    begin failures++; $display("FAIL mid_rst_addr: got %h want 00", reg_addr); end
    if (reg_wr_data !== 8'h00) begin failures++; $display("FAIL mid_rst_wr_data: got %h want 00", reg_wr_data); end
    if (spi_miso_oe !== 1'b0)  begin failures++; $display("FAIL mid_rst_oe: got %b want 0", spi_miso_oe); end
    if (spi_miso !== 1'b0)     begin failures++; $display("FAIL mid_rst_miso: got %b want 0", spi_miso); end
    if (reg_rd_en !== 1'b0 || reg_wr_en !== 1'b0)
      begin failures++; $display("FAIL mid_rst_strobes: got rd=%b wr=%b want 0", reg_rd_en, reg_wr_en); end
    if (frame_err !== 1'b0)    begin failures++; $display("FAIL mid_rst_err: got %b want 0", frame_err); end
    sys_rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    a = 8'($urandom); d = 8'($urandom);
    w0 = wr_cnt;
    run_frame({8'h00, a, d}, 24, 6, 8, 1'b1, so);
    model_mem[a] = d;
    checks += 2;
    if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL mid_rst_recover_wr: got %0d want 1", wr_cnt - w0); end
    if (last_wr_addr !== a || last_wr_data !== d)
      begin failures++; $display("FAIL mid_rst_recover_val: got %h/%h want %h/%h", last_wr_addr, last_wr_data, a, d); end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
    logic [23:0] so;
    logic [7:0] ra, wa, wd, exp_rd;
    ra = 8'($urandom); wa = 8'($urandom); wd = 8'($urandom);
    exp_rd = model_mem[ra];
    run_frame({8'h80, ra, 8'($urandom)}, 24, 4, 4, 1'b1, so);
    run_frame({8'h00, wa, wd}, 24, 4, 4, 1'b1, so);
    model_mem[wa] = wd;
    checks += 4;
    if (rd_cnt - r0 !== 1 || last_rd_addr !== ra)
      begin failures++; $display("FAIL b2b_rd: got cnt=%0d addr=%h want 1/%h", rd_cnt - r0, last_rd_addr, ra); end
    if (wr_cnt - w0 !== 1 || last_wr_addr !== wa || last_wr_data !== wd)
      begin failures++; $display("FAIL b2b_wr: got cnt=%0d %h/%h want 1 %h/%h", wr_cnt - w0, last_wr_addr, last_wr_data, wa, wd); end
    if (err_cnt - e0 !== 0) begin failures++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
    // the read frame's MISO was captured before the write frame overwrote so; re-run the read to check data
    run_frame({8'h80, ra, 8'h00}, 24, 4, 4, 1'b1, so);
    if (so[7:0] !== model_mem[ra]) begin failures++; $display("FAIL b2b_rd_data: got %h want %h", so[7:0], model_mem[ra]); end
    if (ra != wa && exp_rd !== model_mem[ra]) $display("note: model changed unexpectedly");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
      int nbits, half, sel;
      bit rw;
      logic [7:0] a, d;
      logic [23:0] so;
      rw = 1'($urandom); a = 8'($urandom); d = 8'($urandom);
      sel = $urandom_range(0, 9);
      nbits = (sel <= 6) ? 24 : (sel == 7) ? $urandom_range(25, 32) :
              (sel == 8) ? $urandom_range(1, 23) : 0;
      half = $urandom_range(4, 8);
      run_frame({rw, 7'b0, a, d}, nbits, half, 5, 1'b1, so);
      checks += 3;
      if (rd_cnt - r0 !== int'(rw && nbits >= 16))
        begin failures++; $display("FAIL rnd%0d_rd_cnt: got %0d want %0d", n, rd_cnt - r0, int'(rw && nbits >= 16)); end
      if (wr_cnt - w0 !== int'(!rw && nbits >= 24))
        begin failures++; $display("FAIL rnd%0d_wr_cnt: got %0d want %0d", n, wr_cnt - w0, int'(!rw && nbits >= 24)); end
      if (err_cnt - e0 !== int'(nbits > 0 && nbits < 24))
        begin failures++; $display("FAIL rnd%0d_err_cnt: got %0d want %0d", n, err_cnt - e0, int'(nbits > 0 && nbits < 24)); end
      if (nbits >= 24) begin
        checks++;
        if (rw) begin
          if (so[7:0] !== model_mem[a] || last_rd_addr !== a)
            begin failures++; $display("FAIL rnd%0d_read: got %h@%h want %h@%h", n, so[7:0], last_rd_addr, model_mem[a], a); end
        end else begin
          model_mem[a] = d;
          if (last_wr_addr !== a || last_wr_data !== d)
            begin failures++; $display("FAIL rnd%0d_write: got %h/%h want %h/%h", n, last_wr_addr, last_wr_data, a, d); end
        end
      end
    end
    checks++;
    if (both_cnt !== 0) begin failures++; $display("FAIL both_strobes: got %0d want 0", both_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bank[i] = 8'($urandom);
      model_mem[i] = bank[i];
    end
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_long_frame();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
